// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage hazard bundle: decoded operands and branch in, register
// enables, bubble controls and event counters out.
interface hazard_stall_ctrl_if;
  logic        valid_ID;
  logic [4:0]  rs1_ID;
  logic        rs1_use_ID;
  logic [4:0]  rs2_ID;
  logic        rs2_use_ID;
  logic [4:0]  rd_ID;
  logic        reg_write_ID;
  logic        branch_taken_EX;
  logic        en_PC;
  logic        en_IFID;
  logic        NOP_IFID;
  logic        NOP_IDEX;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output valid_ID,
    output rs1_ID,
    output rs1_use_ID,
    output rs2_ID,
    output rs2_use_ID,
    output rd_ID,
    output reg_write_ID,
    output branch_taken_EX,
    input  en_PC,
    input  en_IFID,
    input  NOP_IFID,
    input  NOP_IDEX,
    input  stall_cnt,
    input  flush_cnt
  );

  modport slave (
    input  valid_ID,
    input  rs1_ID,
    input  rs1_use_ID,
    input  rs2_ID,
    input  rs2_use_ID,
    input  rd_ID,
    input  reg_write_ID,
    input  branch_taken_EX,
    output en_PC,
    output en_IFID,
    output NOP_IFID,
    output NOP_IDEX,
    output stall_cnt,
    output flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller beside ID: scoreboards in-flight destinations,
// stalls dependent reads and squashes wrong-path fetches on taken branches.
module hazard_stall_ctrl #(
  parameter int HAZ_DEPTH = 2
) (
  input  logic              clk_HZD,
  input  logic              rst_n_HZD,
  hazard_stall_ctrl_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_ent_t;

  sb_ent_t     sb_q [HAZ_DEPTH];
  sb_ent_t     sb_d [HAZ_DEPTH];
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic flush;
  logic stall;
  logic in_rst;
  logic do_flush;
  logic do_stall;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_q[i].v && (sb_q[i].rd == hz.rs1_ID))
        rs1_hit = 1'b1;
      if (sb_q[i].v && (sb_q[i].rd == hz.rs2_ID))
        rs2_hit = 1'b1;
    end
    // x0 and unused operands can never be hazards
    if (!hz.rs1_use_ID || (hz.rs1_ID == 5'd0))
      rs1_hit = 1'b0;
    if (!hz.rs2_use_ID || (hz.rs2_ID == 5'd0))
      rs2_hit = 1'b0;
  end

  assign hazard = hz.valid_ID & (rs1_hit | rs2_hit);
  assign flush  = hz.branch_taken_EX;
  assign stall  = hazard & ~flush;

  assign in_rst   = ~rst_n_HZD;
  assign do_flush = rst_n_HZD & flush;
  assign do_stall = rst_n_HZD & stall;

  always_comb begin
    hz.en_PC    = 1'b1;
    hz.en_IFID  = 1'b1;
    hz.NOP_IFID = 1'b0;
    hz.NOP_IDEX = 1'b0;
    unique case (1'b1)
      in_rst: begin
        hz.en_PC    = 1'b0;
        hz.en_IFID  = 1'b0;
        hz.NOP_IDEX = 1'b1;
      end
      do_flush: begin
        hz.NOP_IFID = 1'b1;
        hz.NOP_IDEX = 1'b1;
      end
      do_stall: begin
        hz.en_PC    = 1'b0;
        hz.en_IFID  = 1'b0;
        hz.NOP_IDEX = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sb_d[0] = '0;
    if (!flush && !stall) begin
      sb_d[0].v  = hz.valid_ID & hz.reg_write_ID &
                   (hz.rd_ID != 5'd0);
      sb_d[0].rd = hz.rd_ID;
    end
    for (int i = 1; i < HAZ_DEPTH; i++)
      sb_d[i] = sb_q[i-1];
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, flush};
  end

  always_ff @(posedge clk_HZD or negedge rst_n_HZD) begin
    if (!rst_n_HZD) begin
      for (int i = 0; i < HAZ_DEPTH; i++)
        sb_q[i] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 0; i < HAZ_DEPTH; i++)
        sb_q[i] <= sb_d[i];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Stall and flush controller for the 5-stage stall-only pipeline (no forwarding). It drives the enable and NOP-insert controls of the IF/ID and ID/EX pipeline registers. It keeps an internal scoreboard of destination registers for in-flight instructions, stalls the instruction in ID while its sources are still pending, and squashes wrong-path instructions when EX resolves a taken branch. It sits beside the ID stage. Its outputs are consumed by the PC register, the IF/ID register and the ID/EX register.

## Interface
- HAZ_DEPTH, default 2: number of stages after ID whose pending write is not yet visible to an ID-stage register read. With 2, EX and MEM are tracked; WB writes the register file before ID reads it. Legal range is 1..4.
- clk_HZD  in  1  pipeline clock.
- rst_n_HZD  in  1  reset, asynchronous, active-low.
- valid_ID  in  1  ID stage holds a real instruction (the valid output of the IF/ID register).
- rs1_ID  in  5  source register 1 of the ID instruction.
- rs1_use_ID  in  1  the ID instruction reads rs1.
- rs2_ID  in  5  source register 2 of the ID instruction.
- rs2_use_ID  in  1  the ID instruction reads rs2.
- rd_ID  in  5  destination register of the ID instruction.
- reg_write_ID  in  1  the ID instruction writes rd.
- branch_taken_EX  in  1  EX resolved a taken branch or jump this cycle.
- en_PC  out  1  PC register load enable.
- en_IFID  out  1  IF/ID register enable.
- NOP_IFID  out  1  IF/ID loads a NOP (addi x0,x0,0, valid=0). It only takes effect when en_IFID=1.
- NOP_IDEX  out  1  ID/EX loads a bubble this edge.
- stall_cnt  out  32  number of stall cycles since reset.
- flush_cnt  out  32  number of flush cycles since reset.

## Operation
- **Scoreboard:** HAZ_DEPTH entries of {v, rd}. Entry 0 is the instruction in EX; entry HAZ_DEPTH-1 is the oldest tracked instruction.
- **Source match:** a source matches if its use flag is 1, it is not x0, and some entry has v=1 with an equal rd.
- **hazard** = valid_ID & (rs1 match | rs2 match).
- **Flush cycle** (branch_taken_EX=1; takes priority over hazard):
  - en_PC=1, en_IFID=1, NOP_IFID=1, NOP_IDEX=1.
  - flush_cnt increments.
- **Stall cycle** (hazard=1 and branch_taken_EX=0):
  - en_PC=0, en_IFID=0, NOP_IFID=0, NOP_IDEX=1.
  - stall_cnt increments.
- **Run cycle** (neither condition):
  - en_PC=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0.
- **Scoreboard update on each posedge:**
  - Every entry shifts toward the oldest position; the oldest entry is dropped.
  - In a run cycle, entry 0 loads v = valid_ID & reg_write_ID & (rd_ID≠0) and rd = rd_ID.
  - In a stall or flush cycle, entry 0 loads v=0 (a bubble).
- **Counter width:** both counters are 32-bit and wrap from 0xFFFFFFFF to 0 with no saturation.
- **Output timing:** the control outputs are combinational from the current scoreboard state and the ID/EX inputs. They settle within the same cycle and reach the register enables before the next edge.

## Timing
- **Reset (rst_n_HZD=0):**
  - Asynchronously clears all scoreboard entries (v=0, rd=0), stall_cnt=0 and flush_cnt=0.
  - While reset is held, outputs are forced to en_PC=0, en_IFID=0, NOP_IFID=0, NOP_IDEX=1.
- **After reset release:** the scoreboard is empty, so the first cycle with valid_ID=1 is a run cycle.
- **Reset mid-stall:** the scoreboard is lost, so no stall continues after release and the counters restart from 0.
- **Stall length:** when a producer sits at scoreboard index k at the start of the stall, ID stalls for exactly HAZ_DEPTH−k cycles. The ID instruction issues on the following edge.
- **Multiple producers:** if both sources match different entries, the stall lasts until the youngest match (the lowest index) has drained.
- **Same producer on both sources:** counts as a single hazard.
- **Branch during a stall:** that cycle becomes a flush. The stalled ID instruction is squashed, is not issued, and produces no stall-count increment for that cycle.
- **Invalid ID** (valid_ID=0): never stalls. Its rd never enters the scoreboard.
- **Writes to x0:** never enter the scoreboard. Reads of x0 never match.

## Test plan
1. **Back-to-back dependency:** reset, then issue addi x1 followed immediately by add x2,x1,x1 (HAZ_DEPTH=2). Required: 2 stall cycles with en_PC=en_IFID=0 and NOP_IDEX=1, then issue; stall_cnt=2.
2. **One independent instruction between:** issue addi x1, then addi x5, then add x2,x1,x0. Required: exactly 1 stall cycle; stall_cnt=1.
3. **x0 and unused sources:** issue addi x0, then add x3,x0,x0; also issue an instruction with rs2_ID matching but rs2_use_ID=0. Required: 0 stalls in both cases; stall_cnt unchanged.
4. **Branch during a stall:** assert branch_taken_EX=1 in the first stall cycle. Required, that cycle: en_PC=1, en_IFID=1, NOP_IFID=1, NOP_IDEX=1, flush_cnt=1, stall_cnt=0. The next cycle is a run cycle if the new ID instruction has no hazard.
5. **Reset mid-stall:** drive rst_n_HZD low asynchronously between edges during a stall. Required: immediate outputs en_PC=0, en_IFID=0, NOP_IDEX=1; counters read 0. After release with the same ID inputs there is no stall.
6. **Counter wrap:** with stall_cnt preloaded to 0xFFFFFFFF through a bench force, run one stall cycle. Required: stall_cnt=0.
